isp_uart_cmd_rx: RTL and testbench
==================================

# isp_uart_cmd_rx

Fabric-side UART receiver and command-frame decoder on the MSS MMUART_0 transmit line (MMUART_0_TXD_M2F). It deserialises bytes sent by the Cortex-M3 firmware and validates 5-byte command frames. On the authenticated restart command after ISP, it issues a one-cycle restart request toward the device-restart logic. It runs on the fabric CCC clock (FAB_CCC_GL0).

## Interface
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 16..65535
- TIMEOUT_BITS, 20, maximum inter-byte idle gap, in bit times, before a partial frame is aborted
- CLK  in  1  fabric clock (FAB_CCC_GL0)
- RESET  in  1  synchronous, active-high reset
- RXD  in  1  serial input, idle high, asynchronous to CLK
- RX_DATA  out  8  last good byte
- RX_VALID  out  1  one-cycle pulse when RX_DATA is updated
- FRAME_ERR  out  1  one-cycle pulse when a byte's stop bit is sampled low
- CMD_VALID  out  1  one-cycle pulse when a frame passes its checksum
- CMD_CODE  out  8  command byte of the last valid frame
- CMD_ARG  out  16  argument of the last valid frame, {ARG_HI, ARG_LO}
- CHK_ERR  out  1  one-cycle pulse on a checksum mismatch
- RESTART_REQ  out  1  one-cycle pulse when a valid frame has CMD=0x52 and ARG=0xDEAD

## Operation
**Reset values.** All outputs reset to 0. The synchroniser flops reset to 1. Both FSMs reset to their idle states and all counters reset to 0.

**Input synchronisation.** RXD passes through a 2-flop synchroniser. All logic uses only the synchronised signal `rxs`.

**Byte FSM (B_IDLE, B_START, B_DATA, B_STOP, B_BREAK)**
- B_IDLE: `rxs`=0 → B_START and load the bit counter with BAUD_DIV/2 (integer division).
- B_START: when the counter expires, re-sample. If `rxs`=1 it was a false start → B_IDLE. Otherwise → B_DATA with the counter set to BAUD_DIV.
- B_DATA: sample at each expiry, LSB first. After 8 samples → B_STOP.
- B_STOP: at expiry, sample the stop bit.
  - 1: RX_DATA and RX_VALID update on the next clock → B_IDLE.
  - 0: FRAME_ERR pulses, the byte is discarded → B_BREAK.
- B_BREAK: wait for `rxs`=1 → B_IDLE. A held-low line produces exactly one FRAME_ERR.

**Frame FSM (F_SYNC, F_CMD, F_AHI, F_ALO, F_CHK)**
- Frame format: 0xA5, CMD, ARG_HI, ARG_LO, CHK, where CHK = CMD ^ ARG_HI ^ ARG_LO.
- The frame FSM advances on each RX_VALID.
- F_SYNC ignores every byte except 0xA5.
- F_CHK:
  - Match: CMD_CODE and CMD_ARG update and CMD_VALID pulses. If CMD=0x52 and ARG=0xDEAD, RESTART_REQ pulses in the same cycle.
  - Mismatch: CHK_ERR pulses and CMD_CODE/CMD_ARG hold their previous values.
  - In both cases → F_SYNC.
- FRAME_ERR in any frame state → F_SYNC, discarding the partial frame.
- Timeout:
  - An idle counter runs while the frame FSM is outside F_SYNC and clears on each RX_VALID.
  - When it reaches TIMEOUT_BITS*BAUD_DIV the FSM → F_SYNC. No error pulse is issued.
- A 0xA5 received in a non-SYNC state is treated as data, not as a resync.

**RESET mid-byte or mid-frame.** All state is abandoned with no pulses. The next falling edge starts a fresh byte.

## Timing
- **Byte latency.** RX_VALID rises 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after the RXD pin falls for the start bit. The pin timing is taken at the CLK edge where the low level is first captured.
- **Frame latency.** CMD_VALID, CHK_ERR and RESTART_REQ occur exactly 1 cycle after the RX_VALID of the CHK byte.
- **Pulse separation.** Consecutive RX_VALID pulses are at least 10*BAUD_DIV − BAUD_DIV/2 cycles apart. No output pulse ever exceeds one cycle.
- **Throughput.** Back-to-back bytes with zero inter-byte idle (stop bit immediately followed by start) are received without loss.
- **Baud tolerance.** Receiver sampling must tolerate ±2 % baud mismatch.

## Structure
- **Package `isp_uart_pkg`:** SYNC_BYTE=8'hA5, CMD_RESTART=8'h52, RESTART_KEY=16'hDEAD, and the byte-FSM and frame-FSM state typedefs.
- **Sub-module `uart_rx_byte`:** contains the synchroniser, the byte FSM and the bit counter. Its ports are CLK, RESET, RXD, RX_DATA, RX_VALID and FRAME_ERR.
- **Top level:** instantiates `uart_rx_byte` and contains the frame FSM, the timeout counter and the checksum logic.

## Test plan
- **Single byte.** BAUD_DIV=16; send 0x3C with a valid stop bit → one RX_VALID with RX_DATA=0x3C, at exactly the latency formula (2+8+144+1 = 155 cycles), and no FRAME_ERR.
- **Restart frame.** Send A5 52 DE AD 21 back-to-back → CMD_VALID and RESTART_REQ pulse together once, CMD_CODE=0x52, CMD_ARG=0xDEAD.
- **Bad checksum.** Send A5 10 00 01 00 → CHK_ERR once, no CMD_VALID, CMD_CODE and CMD_ARG unchanged. Then send A5 10 00 01 11 → CMD_VALID with CMD_ARG=0x0001 and no RESTART_REQ.
- **Line faults.**
  - 0.3-bit glitch low → no RX_VALID.
  - Byte with stop bit 0 → one FRAME_ERR.
  - Line held low for 30 bit times → still exactly one FRAME_ERR; the following valid byte is received correctly.
- **Timeout.** Send A5 52, idle for 21 bit times, then DE AD 21 → no CMD_VALID. Sending a complete valid frame afterwards → CMD_VALID.
- **Reset mid-frame.** Assert RESET for 1 cycle during the ARG_LO data bits → no pulses. A subsequent full restart frame → RESTART_REQ.

Source files
------------

// File: rtl/isp_uart_pkg.sv
// Shared constants and state types for the ISP UART command receiver.
// frame_chk() gives the checksum byte that a command frame must carry.
package isp_uart_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam logic [7:0]  CMD_RESTART = 8'h52;
  localparam logic [15:0] RESTART_KEY = 16'hDEAD;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_BREAK
  } byte_state_t;

  typedef enum logic [2:0] {
    F_SYNC,
    F_CMD,
    F_AHI,
    F_ALO,
    F_CHK
  } frame_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] arg_hi,
                                           input logic [7:0] arg_lo);
    return cmd ^ arg_hi ^ arg_lo;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: the input synchroniser, the mid-bit sampling FSM and the bit counter.
// A stop bit that reads low raises a single FRAME_ERR, and the FSM then waits for the line to return high.
module uart_rx_byte
  import isp_uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_reg;
  logic          rxs;
  byte_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          stop_done_reg, stop_done_next;
  logic          stop_bit_reg, stop_bit_next;
  logic [7:0]    rx_data_reg;
  logic          rx_valid_reg, frame_err_reg;
  logic          expire;

  assign rxs    = sync_reg[1];
  assign expire = (cnt_reg == CNT_ONE);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    stop_done_next = 1'b0;
    stop_bit_next  = stop_bit_reg;
    case (state_reg)
      B_IDLE: begin
        if (!rxs) begin
          state_next = B_START;
          cnt_next   = HALF_BIT;
        end
      end
      B_START: begin
        if (!expire) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rxs) begin
          state_next = B_IDLE;
        end else begin
          state_next = B_DATA;
          cnt_next   = FULL_BIT;
          bit_next   = 3'd0;
        end
      end
      B_DATA: begin
        if (!expire) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          shift_next = {rxs, shift_reg[7:1]};
          cnt_next   = FULL_BIT;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = B_STOP;
        end
      end
      B_STOP: begin
        if (!expire) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          // Result is reported one clock later from stop_done/stop_bit.
          stop_done_next = 1'b1;
          stop_bit_next  = rxs;
          state_next     = rxs ? B_IDLE : B_BREAK;
        end
      end
      B_BREAK: begin
        if (rxs) state_next = B_IDLE;
      end
      default: state_next = B_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_reg      <= 2'b11;
      state_reg     <= B_IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      stop_done_reg <= 1'b0;
      stop_bit_reg  <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], RXD};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      stop_done_reg <= stop_done_next;
      stop_bit_reg  <= stop_bit_next;
      rx_valid_reg  <= stop_done_reg & stop_bit_reg;
      frame_err_reg <= stop_done_reg & ~stop_bit_reg;
      if (stop_done_reg && stop_bit_reg) rx_data_reg <= shift_reg;
    end
  end

  assign RX_DATA   = rx_data_reg;
  assign RX_VALID  = rx_valid_reg;
  assign FRAME_ERR = frame_err_reg;

endmodule

// File: rtl/isp_uart_cmd_rx.sv
// Command-frame decoder on top of the UART byte receiver: A5, CMD, ARG_HI, ARG_LO, CHK.
// A valid restart frame (0x52 / 0xDEAD) raises RESTART_REQ alongside CMD_VALID.
module isp_uart_cmd_rx
  import isp_uart_pkg::*;
#(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RXD,
  output logic [7:0]  RX_DATA,
  output logic        RX_VALID,
  output logic        FRAME_ERR,
  output logic        CMD_VALID,
  output logic [7:0]  CMD_CODE,
  output logic [15:0] CMD_ARG,
  output logic        CHK_ERR,
  output logic        RESTART_REQ
);

  localparam int TIMEOUT_CYC = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] IDLE_ONE    = TW'(1);

  frame_state_t  state_reg, state_next;
  logic [TW-1:0] idle_reg, idle_next;
  logic [7:0]    cmd_reg, cmd_next;
  logic [7:0]    ahi_reg, ahi_next;
  logic [7:0]    alo_reg, alo_next;
  logic [7:0]    code_reg, code_next;
  logic [15:0]   arg_reg, arg_next;
  logic          cmd_valid_reg, cmd_valid_next;
  logic          chk_err_reg, chk_err_next;
  logic          restart_reg, restart_next;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx_byte (
    .CLK       (CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .FRAME_ERR (FRAME_ERR)
  );

  always_comb begin
    state_next     = state_reg;
    idle_next      = idle_reg;
    cmd_next       = cmd_reg;
    ahi_next       = ahi_reg;
    alo_next       = alo_reg;
    code_next      = code_reg;
    arg_next       = arg_reg;
    cmd_valid_next = 1'b0;
    chk_err_next   = 1'b0;
    restart_next   = 1'b0;

    // Inter-byte idle timer only matters while a frame is partially received.
    if (state_reg == F_SYNC || RX_VALID) idle_next = '0;
    else if (idle_reg != TIMEOUT_LIM)    idle_next = idle_reg + IDLE_ONE;

    if (FRAME_ERR) begin
      state_next = F_SYNC;
    end else if (RX_VALID) begin
      case (state_reg)
        F_SYNC: if (RX_DATA == SYNC_BYTE) state_next = F_CMD;
        F_CMD: begin
          cmd_next   = RX_DATA;
          state_next = F_AHI;
        end
        F_AHI: begin
          ahi_next   = RX_DATA;
          state_next = F_ALO;
        end
        F_ALO: begin
          alo_next   = RX_DATA;
          state_next = F_CHK;
        end
        F_CHK: begin
          if (RX_DATA == frame_chk(cmd_reg, ahi_reg, alo_reg)) begin
            cmd_valid_next = 1'b1;
            code_next      = cmd_reg;
            arg_next       = {ahi_reg, alo_reg};
            restart_next   = (cmd_reg == CMD_RESTART) && ({ahi_reg, alo_reg} == RESTART_KEY);
          end else begin
            chk_err_next = 1'b1;
          end
          state_next = F_SYNC;
        end
        default: state_next = F_SYNC;
      endcase
    end else if (idle_reg == TIMEOUT_LIM) begin
      state_next = F_SYNC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= F_SYNC;
      idle_reg      <= '0;
      cmd_reg       <= '0;
      ahi_reg       <= '0;
      alo_reg       <= '0;
      code_reg      <= '0;
      arg_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      chk_err_reg   <= 1'b0;
      restart_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idle_reg      <= idle_next;
      cmd_reg       <= cmd_next;
      ahi_reg       <= ahi_next;
      alo_reg       <= alo_next;
      code_reg      <= code_next;
      arg_reg       <= arg_next;
      cmd_valid_reg <= cmd_valid_next;
      chk_err_reg   <= chk_err_next;
      restart_reg   <= restart_next;
    end
  end

  assign CMD_VALID   = cmd_valid_reg;
  assign CMD_CODE    = code_reg;
  assign CMD_ARG     = arg_reg;
  assign CHK_ERR     = chk_err_reg;
  assign RESTART_REQ = restart_reg;

endmodule

// File: tb/tb_isp_uart_cmd_rx.sv
// Bench for isp_uart_cmd_rx: directed line/frame scenarios plus randomised byte streams
// checked against a byte-list frame model.
module tb_isp_uart_cmd_rx;

  localparam int B  = 16;
  localparam int TO = 20;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RXD;
  logic [7:0]  RX_DATA;
  logic        RX_VALID, FRAME_ERR, CMD_VALID, CHK_ERR, RESTART_REQ;
  logic [7:0]  CMD_CODE;
  logic [15:0] CMD_ARG;

  isp_uart_cmd_rx #(.BAUD_DIV(B), .TIMEOUT_BITS(TO)) dut (
    .CLK(CLK), .RESET(RESET), .RXD(RXD), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .FRAME_ERR(FRAME_ERR), .CMD_VALID(CMD_VALID), .CMD_CODE(CMD_CODE), .CMD_ARG(CMD_ARG),
    .CHK_ERR(CHK_ERR), .RESTART_REQ(RESTART_REQ)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fall_cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [7:0] b; bit ok; int gap; } item_t;
  item_t      items[$];
  logic [7:0] exp_rx[$];
  logic [23:0] exp_cmd[$];
  int exp_ferr, exp_chk, exp_rst;

  // Monitor: observed pulses, sampled on the falling edge.
  logic [7:0]  rx_q[$];
  int          rv_cyc_q[$];
  logic [24:0] cmd_q[$];
  int ferr_n = 0, chk_n = 0, rst_n = 0, long_n = 0, lat_bad = 0, last_rv_cyc = 0;
  logic [4:0] pulses, prev_pulses = '0;
  assign pulses = {RX_VALID === 1'b1, FRAME_ERR === 1'b1, CMD_VALID === 1'b1,
                   CHK_ERR === 1'b1, RESTART_REQ === 1'b1};

  always @(negedge CLK) begin
    if (pulses[4]) begin
      rx_q.push_back(RX_DATA);
      rv_cyc_q.push_back(cyc);
      last_rv_cyc <= cyc;
    end
    if (pulses[3]) ferr_n <= ferr_n + 1;
    if (pulses[1]) chk_n <= chk_n + 1;
    if (pulses[0]) rst_n <= rst_n + 1;
    if (pulses[2]) cmd_q.push_back({RESTART_REQ, CMD_CODE, CMD_ARG});
    if ((pulses[2] || pulses[1]) && cyc != last_rv_cyc + 1) lat_bad <= lat_bad + 1;
    if ((prev_pulses & pulses) != 5'b0) long_n <= long_n + 1;
    prev_pulses <= pulses;
  end

  task automatic clear_mon();
    rx_q.delete(); rv_cyc_q.delete(); cmd_q.delete();
    ferr_n = 0; chk_n = 0; rst_n = 0; long_n = 0; lat_bad = 0;
  endtask

  task automatic drive_bit(input logic v);
    RXD = v;
    repeat (B) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    $display("tx byte=%h stop=%0d gap=%0d cyc=%0d", b, ok, gap, cyc);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(logic'(ok));
    RXD = 1'b1;
    repeat (gap * B) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k);
    send_byte(8'hA5, 1, 0); send_byte(c, 1, 0); send_byte(h, 1, 0);
    send_byte(l, 1, 0); send_byte(k, 1, 2);
  endtask

  task automatic idle_bits(input int n);
    RXD = 1'b1;
    repeat (n * B) @(negedge CLK);
  endtask

  // Frame model over the list of sent bytes: collect A5 + 4 bytes, check XOR.
  task automatic run_model();
    int pos;
    logic [7:0] fr [1:3];
    pos = 0;
    exp_rx.delete(); exp_cmd.delete();
    exp_ferr = 0; exp_chk = 0; exp_rst = 0;
    foreach (items[i]) begin
      if (!items[i].ok) begin
        exp_ferr++;
        pos = 0;
      end else begin
        exp_rx.push_back(items[i].b);
        if (pos == 0) begin
          if (items[i].b == 8'hA5) pos = 1;
        end else if (pos < 4) begin
          fr[pos] = items[i].b;
          pos++;
        end else begin
          if ((fr[1] ^ fr[2] ^ fr[3]) == items[i].b) begin
            exp_cmd.push_back({fr[1], fr[2], fr[3]});
            if (fr[1] == 8'h52 && {fr[2], fr[3]} == 16'hDEAD) exp_rst++;
          end else begin
            exp_chk++;
          end
          pos = 0;
        end
      end
      if (items[i].gap > TO) pos = 0;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; RXD = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if (pulses !== 5'b0) begin miscompares++; $display("FAIL reset_pulses: got %b, expected 00000", pulses); end
    vectors++;
    if (RX_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h, expected 00", RX_DATA); end
    vectors++;
    if ({CMD_CODE, CMD_ARG} !== 24'h0) begin miscompares++; $display("FAIL reset_cmd: got %h, expected 000000", {CMD_CODE, CMD_ARG}); end
    RESET = 1'b0;
    clear_mon();
    idle_bits(2);
    vectors++;
    if (rx_q.size() + ferr_n != 0) begin miscompares++; $display("FAIL reset_idle: got %0d events, expected 0", rx_q.size() + ferr_n); end
  endtask

  task automatic test_single_byte();
    clear_mon();
    send_byte(8'h3C, 1, 2);
    vectors++;
    if (rx_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d, expected 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      vectors++;
      if (rx_q[0] !== 8'h3C) begin miscompares++; $display("FAIL single_data: got %h, expected 3c", rx_q[0]); end
      vectors++;
      if (rv_cyc_q[0] - fall_cyc - 1 != 2 + B / 2 + 9 * B + 1)
        begin miscompares++; $display("FAIL single_latency: got %0d, expected %0d", rv_cyc_q[0] - fall_cyc - 1, 2 + B / 2 + 9 * B + 1); end
    end
    vectors++;
    if (ferr_n != 0) begin miscompares++; $display("FAIL single_ferr: got %0d, expected 0", ferr_n); end
  endtask

  task automatic test_restart_frame();
    clear_mon();
    send_frame(8'h52, 8'hDE, 8'hAD, 8'h21);
    vectors++;
    if (cmd_q.size() != 1) begin miscompares++; $display("FAIL restart_cmd_count: got %0d, expected 1", cmd_q.size()); end
    if (cmd_q.size() > 0) begin
      vectors++;
      if (cmd_q[0] !== {1'b1, 8'h52, 16'hDEAD}) begin miscompares++; $display("FAIL restart_cmd: got %h, expected 152dead", cmd_q[0]); end
    end
    vectors++;
    if (rst_n != 1) begin miscompares++; $display("FAIL restart_req_count: got %0d, expected 1", rst_n); end
    vectors++;
    if ({CMD_CODE, CMD_ARG} !== 24'h52DEAD) begin miscompares++; $display("FAIL restart_outputs: got %h, expected 52dead", {CMD_CODE, CMD_ARG}); end
    vectors++;
    if (lat_bad + long_n + chk_n != 0) begin miscompares++; $display("FAIL restart_timing: got %0d bad events, expected 0", lat_bad + long_n + chk_n); end
  endtask

  task automatic test_bad_checksum();
    clear_mon();
    send_frame(8'h10, 8'h00, 8'h01, 8'h00);
    vectors++;
    if (chk_n != 1) begin miscompares++; $display("FAIL badchk_count: got %0d, expected 1", chk_n); end
    vectors++;
    if (cmd_q.size() != 0) begin miscompares++; $display("FAIL badchk_cmd_valid: got %0d, expected 0", cmd_q.size()); end
    vectors++;
    if ({CMD_CODE, CMD_ARG} !== 24'h52DEAD) begin miscompares++; $display("FAIL badchk_hold: got %h, expected 52dead", {CMD_CODE, CMD_ARG}); end
    clear_mon();
    send_frame(8'h10, 8'h00, 8'h01, 8'h11);
    vectors++;
    if (cmd_q.size() != 1) begin miscompares++; $display("FAIL goodchk_count: got %0d, expected 1", cmd_q.size()); end
    if (cmd_q.size() > 0) begin
      vectors++;
      if (cmd_q[0] !== {1'b0, 8'h10, 16'h0001}) begin miscompares++; $display("FAIL goodchk_cmd: got %h, expected 0100001", cmd_q[0]); end
    end
    vectors++;
    if (rst_n + chk_n + lat_bad != 0) begin miscompares++; $display("FAIL goodchk_extra: got %0d, expected 0", rst_n + chk_n + lat_bad); end
  endtask

  task automatic test_line_faults();
    clear_mon();
    RXD = 1'b0;
    repeat ((3 * B) / 10) @(negedge CLK);
    idle_bits(3);
    vectors++;
    if (rx_q.size() + ferr_n != 0) begin miscompares++; $display("FAIL glitch: got %0d events, expected 0", rx_q.size() + ferr_n); end
    clear_mon();
    send_byte(8'h55, 0, 3);
    vectors++;
    if (ferr_n != 1 || rx_q.size() != 0) begin miscompares++; $display("FAIL bad_stop: got ferr=%0d rx=%0d, expected ferr=1 rx=0", ferr_n, rx_q.size()); end
    clear_mon();
    RXD = 1'b0;
    repeat (30 * B) @(negedge CLK);
    idle_bits(2);
    send_byte(8'h96, 1, 2);
    vectors++;
    if (ferr_n != 1) begin miscompares++; $display("FAIL break_ferr: got %0d, expected 1", ferr_n); end
    vectors++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin miscompares++; $display("FAIL break_recover: got %0d bytes, expected one byte 96", rx_q.size()); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'hA5, 1, 0);
    send_byte(8'h52, 1, TO + 1);
    send_byte(8'hDE, 1, 0);
    send_byte(8'hAD, 1, 0);
    send_byte(8'h21, 1, 2);
    vectors++;
    if (cmd_q.size() + chk_n != 0) begin miscompares++; $display("FAIL timeout_abort: got %0d frame events, expected 0", cmd_q.size() + chk_n); end
    vectors++;
    if (rx_q.size() != 5) begin miscompares++; $display("FAIL timeout_bytes: got %0d, expected 5", rx_q.size()); end
    clear_mon();
    send_frame(8'h52, 8'hDE, 8'hAD, 8'h21);
    vectors++;
    if (cmd_q.size() != 1) begin miscompares++; $display("FAIL timeout_recover: got %0d, expected 1", cmd_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_byte(8'hA5, 1, 0);
    send_byte(8'h52, 1, 0);
    send_byte(8'hDE, 1, 0);
    fork
      send_byte(8'hAD, 1, 2);
      begin
        repeat (8 * B + 4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
      end
    join
    idle_bits(2);
    vectors++;
    if (rx_q.size() != 3 || ferr_n + chk_n + rst_n + cmd_q.size() != 0)
      begin miscompares++; $display("FAIL rst_mid_pulses: got rx=%0d other=%0d, expected rx=3 other=0", rx_q.size(), ferr_n + chk_n + rst_n + cmd_q.size()); end
    vectors++;
    if ({CMD_CODE, CMD_ARG} !== 24'h0) begin miscompares++; $display("FAIL rst_mid_cmd: got %h, expected 000000", {CMD_CODE, CMD_ARG}); end
    clear_mon();
    send_frame(8'h52, 8'hDE, 8'hAD, 8'h21);
    vectors++;
    if (rst_n != 1 || cmd_q.size() != 1) begin miscompares++; $display("FAIL rst_mid_restart: got rst=%0d cmd=%0d, expected 1 1", rst_n, cmd_q.size()); end
  endtask

  task automatic test_random();
    int kind;
    logic [7:0] c, h, l, k;
    idle_bits(TO + 5);
    items.delete();
    for (int g = 0; g < 20; g++) begin
      kind = int'($urandom_range(0, 5));
      c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      if (kind == 1) begin c = 8'h52; h = 8'hDE; l = 8'hAD; end
      k = c ^ h ^ l;
      if (kind == 2) k = k ^ (8'd1 << $urandom_range(0, 7));
      case (kind)
        0, 1, 2: begin
          items.push_back('{8'hA5, 1'b1, int'($urandom_range(0, 3))});
          items.push_back('{c, 1'b1, int'($urandom_range(0, 3))});
          items.push_back('{h, 1'b1, int'($urandom_range(0, 3))});
          items.push_back('{l, 1'b1, int'($urandom_range(0, 3))});
          items.push_back('{k, 1'b1, int'($urandom_range(0, 3))});
        end
        3: items.push_back('{c, 1'b1, int'($urandom_range(0, 3))});
        4: items.push_back('{c, 1'b0, int'($urandom_range(2, 3))});
        default: begin
          items.push_back('{8'hA5, 1'b1, int'($urandom_range(0, 3))});
          items.push_back('{c, 1'b1, int'($urandom_range(0, 3))});
          items.push_back('{h, 1'b1, int'($urandom_range(TO + 2, TO + 6))});
        end
      endcase
      if ($urandom_range(0, 3) == 0) items[items.size() - 1].gap = int'($urandom_range(TO + 2, TO + 6));
    end
    run_model();
    clear_mon();
    foreach (items[i]) send_byte(items[i].b, items[i].ok, items[i].gap);
    idle_bits(2);
    vectors++;
    if (rx_q.size() != exp_rx.size()) begin miscompares++; $display("FAIL rand_rx_count: got %0d, expected %0d", rx_q.size(), exp_rx.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++) begin
      vectors++;
      if (rx_q[i] !== exp_rx[i]) begin miscompares++; $display("FAIL rand_rx[%0d]: got %h, expected %h", i, rx_q[i], exp_rx[i]); end
    end
    vectors++;
    if (cmd_q.size() != exp_cmd.size()) begin miscompares++; $display("FAIL rand_cmd_count: got %0d, expected %0d", cmd_q.size(), exp_cmd.size()); end
    for (int i = 0; i < cmd_q.size() && i < exp_cmd.size(); i++) begin
      vectors++;
      if (cmd_q[i] !== {exp_cmd[i] == 24'h52DEAD, exp_cmd[i]})
        begin miscompares++; $display("FAIL rand_cmd[%0d]: got %h, expected %h", i, cmd_q[i], {exp_cmd[i] == 24'h52DEAD, exp_cmd[i]}); end
    end
    vectors++;
    if (ferr_n != exp_ferr) begin miscompares++; $display("FAIL rand_ferr: got %0d, expected %0d", ferr_n, exp_ferr); end
    vectors++;
    if (chk_n != exp_chk) begin miscompares++; $display("FAIL rand_chk: got %0d, expected %0d", chk_n, exp_chk); end
    vectors++;
    if (rst_n != exp_rst) begin miscompares++; $display("FAIL rand_restart: got %0d, expected %0d", rst_n, exp_rst); end
    vectors++;
    if (lat_bad + long_n != 0) begin miscompares++; $display("FAIL rand_timing: got %0d bad pulses, expected 0", lat_bad + long_n); end
  endtask

  initial begin
    RESET = 1'b1;
    RXD   = 1'b1;
    test_reset();
    test_single_byte();
    test_restart_frame();
    test_bad_checksum();
    test_line_faults();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
